uart_cmd_parser: RTL and testbench
==================================

# uart_cmd_parser

Byte-stream command framer placed directly downstream of the UART receiver: it consumes received bytes and their one-cycle ready strobe, hunts for a sync byte, and collects an address/length/payload/checksum frame into a local buffer. After the checksum verifies, it replays the payload as sequential register writes. Malformed, corrupted or stalled frames are dropped and reported with an error pulse and code; no partial writes are ever issued.

## Interface
- SYNC_BYTE, 8'hAA, frame start marker
- MAX_LEN, 16, maximum payload bytes per frame (1..255)
- TIMEOUT_CYC, 50000, max clk_in cycles allowed between bytes inside a frame (5 ms at 10 MHz)
- clk_in  in  1  clock
- rst_in  in  1  reset, asynchronous, active-high
- rx_data_in  in  8  received byte, valid when rx_valid_in=1
- rx_valid_in  in  1  one-cycle byte strobe from UART receiver
- wr_en_out  out  1  register write strobe, one cycle per payload byte
- wr_addr_out  out  8  write address
- wr_data_out  out  8  write data
- frame_ok_out  out  1  one-cycle pulse, frame accepted and fully written
- frame_err_out  out  1  one-cycle pulse, frame dropped
- err_code_out  out  2  1=bad length, 2=checksum, 3=timeout; holds last error code
- busy_out  out  1  high in every state except HUNT

## Operation
- Frame: SYNC_BYTE, ADDR, LEN, D[0..LEN-1], CSUM. Valid when (ADDR+LEN+sum D+CSUM) mod 256 = 0.
- States: HUNT, ADDR, LEN, DATA, CSUM, REPLAY.
- HUNT: byte == SYNC_BYTE -> ADDR, clear running sum; any other byte is silently discarded.
- ADDR: latch base address, add to sum -> LEN.
- LEN: LEN=0 or LEN>MAX_LEN -> frame_err, code 1, -> HUNT. Otherwise latch LEN, add to sum, clear index -> DATA.
- DATA: store byte at buffer[index], add to sum, increment index; after LEN-th byte -> CSUM. SYNC_BYTE inside payload is ordinary data; no resync.
- CSUM: (sum+byte) mod 256 = 0 -> REPLAY; else frame_err, code 2, -> HUNT.
- REPLAY: one write per cycle, wr_addr_out = (ADDR+i) mod 256 (wraps 0xFF->0x00), wr_data_out = buffer[i], i = 0..LEN-1; then frame_ok pulse -> HUNT.
- rx_valid_in during REPLAY: byte ignored, no error.
- Timeout: counter clears on every rx_valid_in and on entering ADDR. In ADDR/LEN/DATA/CSUM, reaching TIMEOUT_CYC cycles with no byte -> frame_err, code 3, -> HUNT. Counter is idle in HUNT and REPLAY.
- Sum is 8-bit with wrap. Index/length counters are $clog2(MAX_LEN+1) bits; timeout counter is $clog2(TIMEOUT_CYC+1) bits.
- Buffer: MAX_LEN x 8 registers or distributed RAM; contents are don't-care outside a frame.

## Timing
- All outputs registered. Reset values: wr_en_out=0, wr_addr_out=0, wr_data_out=0, frame_ok_out=0, frame_err_out=0, err_code_out=0, busy_out=0; state HUNT; sum, index and timeout counter 0.
- Every parsing state accepts a byte on any cycle, including back-to-back rx_valid_in on consecutive cycles.
- CSUM byte strobed at cycle T: wr_en_out high at T+1..T+LEN with the same-cycle address and data; frame_ok_out high at T+LEN+1; busy_out falls at T+LEN+2.
- Bad-length or checksum byte at T: frame_err_out and err_code_out update at T+1, with no wr_en_out; state HUNT at T+1, so a SYNC_BYTE at T+1 starts a new frame.
- Timeout: frame_err_out fires exactly TIMEOUT_CYC+1 cycles after the last strobed byte.
- frame_ok_out and frame_err_out are never high together.
- rst_in asserted mid-frame or mid-REPLAY: outputs go to reset values immediately; remaining writes are abandoned; no ok or error pulse.

## Test plan
- Clean frame AA 10 02 01 02 EB -> wr (0x10,0x01) at T+1 and (0x11,0x02) at T+2, frame_ok at T+3, no frame_err.
- Address wrap plus leading noise: 00 13 AA FF 02 55 66 44 -> noise ignored; writes (0xFF,0x55), (0x00,0x66); frame_ok.
- Checksum error: AA 10 02 01 02 EC -> frame_err at T+1, err_code=2, zero writes; immediately following good frame is accepted.
- Length errors: AA 10 00 -> err_code=1; AA 10 11 (MAX_LEN=16) -> err_code=1; parser back in HUNT for both.
- Timeout with TIMEOUT_CYC=100: AA 10 02 01 then silence -> frame_err at 101 cycles after the 0x01 strobe, err_code=3; a 99-cycle gap between bytes does not time out.
- Back-to-back strobes and reset: a full 16-byte frame on consecutive cycles -> 16 writes; rst_in pulsed during the 8th replay write -> wr_en_out=0 at once, no frame_ok, next frame parses normally.

Source files
------------

// File: rtl/uart_cmd_if.sv
// Byte-stream input and register-write output bundle of the UART command parser.
// The parser uses the slave view; the byte source / write consumer uses master.
interface uart_cmd_if;
  logic [7:0] rx_data_in;
  logic       rx_valid_in;
  logic       wr_en_out;
  logic [7:0] wr_addr_out;
  logic [7:0] wr_data_out;
  logic       frame_ok_out;
  logic       frame_err_out;
  logic [1:0] err_code_out;
  logic       busy_out;

  modport slave (
    input  rx_data_in,
    input  rx_valid_in,
    output wr_en_out,
    output wr_addr_out,
    output wr_data_out,
    output frame_ok_out,
    output frame_err_out,
    output err_code_out,
    output busy_out
  );

  modport master (
    output rx_data_in,
    output rx_valid_in,
    input  wr_en_out,
    input  wr_addr_out,
    input  wr_data_out,
    input  frame_ok_out,
    input  frame_err_out,
    input  err_code_out,
    input  busy_out
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Frames SYNC/ADDR/LEN/DATA/CSUM commands from the UART byte stream and replays
// verified payloads as sequential register writes; bad frames are dropped whole.
//
//   state     | meaning
//   ----------+-------------------------------------------------
//   ST_HUNT   | idle, discard bytes until SYNC_BYTE
//   ST_ADDR   | waiting for base address byte
//   ST_LEN    | waiting for length byte, range-checked
//   ST_DATA   | collecting LEN payload bytes into buffer
//   ST_CSUM   | waiting for checksum byte
//   ST_REPLAY | issuing one write per cycle, then frame_ok
module uart_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE   = 8'hAA,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  uart_cmd_if.slave   bus
);

  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_ADDR,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_REPLAY
  } state_t;

  state_t state_q, state_d;

  logic [7:0]    sum_q;
  logic [7:0]    base_q;
  logic [IW-1:0] len_q;
  logic [IW-1:0] idx_q;
  logic [TW-1:0] tcnt_q;
  logic [7:0]    buf_mem [MAX_LEN];

  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       ok_q, ok_d;
  logic       err_q, err_d;
  logic [1:0] code_q, code_d;
  logic       busy_q, busy_d;

  logic          rx_v;
  logic [7:0]    rx_b;
  logic [7:0]    sum_nxt;
  logic          len_bad;
  logic          csum_good;
  logic          parsing;
  logic          tmo;
  logic          data_last;
  logic [IW-1:0] rep_nxt;
  logic          rep_more;
  logic          rep_done;

  assign rx_v      = bus.rx_valid_in;
  assign rx_b      = bus.rx_data_in;
  assign sum_nxt   = sum_q + rx_b;
  assign len_bad   = (rx_b == 8'h00) || (rx_b > MAX_LEN_B);
  assign csum_good = (sum_nxt == 8'h00);
  assign parsing   = (state_q == ST_ADDR) || (state_q == ST_LEN) ||
                     (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign tmo       = parsing && !rx_v && (tcnt_q == TMO_LAST);
  assign data_last = (idx_q == len_q - 1'b1);
  assign rep_nxt   = idx_q + 1'b1;
  assign rep_more  = (rep_nxt < len_q);
  // idx_q == len_q marks the extra REPLAY cycle that carries frame_ok
  assign rep_done  = (idx_q == len_q);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= ST_HUNT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HUNT: begin
        if (rx_v && rx_b == SYNC_BYTE) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (rx_v)     state_d = ST_LEN;
        else if (tmo) state_d = ST_HUNT;
      end
      ST_LEN: begin
        if (rx_v)     state_d = len_bad ? ST_HUNT : ST_DATA;
        else if (tmo) state_d = ST_HUNT;
      end
      ST_DATA: begin
        if (rx_v && data_last) state_d = ST_CSUM;
        else if (tmo)          state_d = ST_HUNT;
      end
      ST_CSUM: begin
        if (rx_v)     state_d = csum_good ? ST_REPLAY : ST_HUNT;
        else if (tmo) state_d = ST_HUNT;
      end
      ST_REPLAY: begin
        if (rep_done) state_d = ST_HUNT;
      end
      default: state_d = ST_HUNT;
    endcase
  end

  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    code_d    = code_q;
    busy_d    = (state_d != ST_HUNT);
    if (tmo) begin
      err_d  = 1'b1;
      code_d = 2'd3;
    end
    case (state_q)
      ST_LEN: begin
        if (rx_v && len_bad) begin
          err_d  = 1'b1;
          code_d = 2'd1;
        end
      end
      ST_CSUM: begin
        if (rx_v) begin
          if (csum_good) begin
            wr_en_d   = 1'b1;
            wr_addr_d = base_q;
            wr_data_d = buf_mem[0];
          end else begin
            err_d  = 1'b1;
            code_d = 2'd2;
          end
        end
      end
      ST_REPLAY: begin
        if (rep_more) begin
          wr_en_d   = 1'b1;
          wr_addr_d = base_q + 8'(rep_nxt);
          wr_data_d = buf_mem[rep_nxt[AW-1:0]];
        end else if (!rep_done) begin
          ok_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= 8'h00;
      wr_data_q <= 8'h00;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= 2'd0;
      busy_q    <= 1'b0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      code_q    <= code_d;
      busy_q    <= busy_d;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sum_q  <= 8'h00;
      base_q <= 8'h00;
      len_q  <= '0;
      idx_q  <= '0;
      tcnt_q <= '0;
    end else begin
      // Silence counter only runs while a frame is being collected
      if (parsing && !rx_v && state_d != ST_HUNT) tcnt_q <= tcnt_q + 1'b1;
      else                                        tcnt_q <= '0;
      case (state_q)
        ST_HUNT: begin
          if (rx_v && rx_b == SYNC_BYTE) sum_q <= 8'h00;
        end
        ST_ADDR: begin
          if (rx_v) begin
            base_q <= rx_b;
            sum_q  <= sum_nxt;
          end
        end
        ST_LEN: begin
          if (rx_v && !len_bad) begin
            len_q <= IW'(rx_b);
            sum_q <= sum_nxt;
            idx_q <= '0;
          end
        end
        ST_DATA: begin
          if (rx_v) begin
            sum_q <= sum_nxt;
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_CSUM: begin
          if (rx_v && csum_good) idx_q <= '0;
        end
        ST_REPLAY: begin
          if (!rep_done) idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Payload storage needs no reset; it is always written before being read
  always_ff @(posedge clk_in) begin
    if (state_q == ST_DATA && rx_v) buf_mem[idx_q[AW-1:0]] <= rx_b;
  end

  assign bus.wr_en_out     = wr_en_q;
  assign bus.wr_addr_out   = wr_addr_q;
  assign bus.wr_data_out   = wr_data_q;
  assign bus.frame_ok_out  = ok_q;
  assign bus.frame_err_out = err_q;
  assign bus.err_code_out  = code_q;
  assign bus.busy_out      = busy_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed frames plus random frames, checked against
// a frame-level model that walks the sent byte list.
module tb_uart_cmd_parser;
  localparam int MAX_LEN = 16;
  localparam int TMO     = 100;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  uart_cmd_if u();

  uart_cmd_parser #(
    .SYNC_BYTE  (8'hAA),
    .MAX_LEN    (MAX_LEN),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (u)
  );

  always #5 clk_in = ~clk_in;

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // observation side
  logic [15:0] obs_wr[$];
  int          n_ok, n_err, n_both;
  int unsigned first_wr_cyc, ok_cyc, err_cyc, busy_fall_cyc;
  logic        busy_prev = 1'b0;

  always @(negedge clk_in) begin
    if (u.wr_en_out === 1'b1) begin
      if (obs_wr.size() == 0) first_wr_cyc = cyc;
      obs_wr.push_back({u.wr_addr_out, u.wr_data_out});
    end
    if (u.frame_ok_out === 1'b1) begin
      if (n_ok == 0) ok_cyc = cyc;
      n_ok++;
    end
    if (u.frame_err_out === 1'b1) begin
      if (n_err == 0) err_cyc = cyc;
      n_err++;
    end
    if (u.frame_ok_out === 1'b1 && u.frame_err_out === 1'b1) n_both++;
    if (busy_prev === 1'b1 && u.busy_out === 1'b0) busy_fall_cyc = cyc;
    busy_prev = u.busy_out;
  end

  task automatic clear_obs();
    obs_wr.delete();
    n_ok = 0; n_err = 0;
    first_wr_cyc = 0; ok_cyc = 0; err_cyc = 0; busy_fall_cyc = 0;
  endtask

  // stimulus side
  logic [7:0]  stim[$];
  int unsigned sc[$];

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk_in);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    u.rx_data_in  = b;
    u.rx_valid_in = 1'b1;
    @(posedge clk_in);
    #1;
    u.rx_valid_in = 1'b0;
    sc.push_back(cyc);
  endtask

  task automatic send_stim(input int gap_lo, input int gap_hi);
    sc.delete();
    foreach (stim[k]) begin
      if (k > 0) idle(int'($urandom_range(gap_hi, gap_lo)));
      send_byte(stim[k]);
    end
  endtask

  // cycle of an observation counted from the strobe cycle of byte idx (strobe = 0)
  function automatic int rel(input int unsigned c, input int idx);
    return int'(c) - int'(sc[idx]) + 1;
  endfunction

  // reference model: frame-level walk of the byte list
  logic [15:0] exp_wr[$];
  int          exp_ok, exp_err;
  logic [1:0]  exp_code = 2'd0;

  function automatic void model_stream();
    int i = 0;
    int n = stim.size();
    exp_wr.delete();
    exp_ok = 0;
    exp_err = 0;
    while (i < n) begin
      int a, l, s;
      if (stim[i] != 8'hAA) begin
        i++;
        continue;
      end
      if (i + 2 >= n) break;
      a = stim[i+1];
      l = stim[i+2];
      if (l == 0 || l > MAX_LEN) begin
        exp_err++;
        exp_code = 2'd1;
        i += 3;
        continue;
      end
      if (i + 3 + l >= n) break;
      s = a + l + stim[i+3+l];
      for (int j = 0; j < l; j++) s += stim[i+3+j];
      if (s % 256 == 0) begin
        for (int j = 0; j < l; j++) exp_wr.push_back({8'(a + j), stim[i+3+j]});
        exp_ok++;
        break;
      end
      exp_err++;
      exp_code = 2'd2;
      i += 4 + l;
    end
  endfunction

  task automatic wait_idle(input string tag);
    int quiet = 0;
    int k = 0;
    while (quiet < 3 && k < 500) begin
      @(negedge clk_in);
      k++;
      if (u.busy_out === 1'b0) quiet++;
      else quiet = 0;
    end
    check({tag, "_idle"}, quiet, 3);
    @(posedge clk_in);
    #1;
  endtask

  task automatic compare_results(input string tag);
    int m = (obs_wr.size() < exp_wr.size()) ? obs_wr.size() : exp_wr.size();
    check({tag, "_nwr"}, obs_wr.size(), exp_wr.size());
    for (int j = 0; j < m; j++) check({tag, "_wr"}, obs_wr[j], exp_wr[j]);
    check({tag, "_nok"}, n_ok, exp_ok);
    check({tag, "_nerr"}, n_err, exp_err);
    check({tag, "_code"}, u.err_code_out, exp_code);
  endtask

  task automatic run_stream(input string tag, input int gap_lo, input int gap_hi);
    clear_obs();
    send_stim(gap_lo, gap_hi);
    wait_idle(tag);
    model_stream();
    compare_results(tag);
  endtask

  task automatic build_frame(input logic [7:0] a, input int l, input bit corrupt);
    int s = a + l;
    stim.push_back(8'hAA);
    stim.push_back(a);
    stim.push_back(8'(l));
    for (int j = 0; j < l; j++) begin
      logic [7:0] d = 8'($urandom);
      stim.push_back(d);
      s += d;
    end
    s = (256 - (s % 256)) % 256;
    if (corrupt) s += int'($urandom_range(255, 1));
    stim.push_back(8'(s));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr_en"}, u.wr_en_out, 1'b0);
    check({tag, "_wr_addr"}, u.wr_addr_out, 8'h00);
    check({tag, "_wr_data"}, u.wr_data_out, 8'h00);
    check({tag, "_ok"}, u.frame_ok_out, 1'b0);
    check({tag, "_err"}, u.frame_err_out, 1'b0);
    check({tag, "_code"}, u.err_code_out, 2'd0);
    check({tag, "_busy"}, u.busy_out, 1'b0);
  endtask

  initial begin
    u.rx_data_in  = 8'h00;
    u.rx_valid_in = 1'b0;
    rst_in = 1'b1;
    clear_obs();
    idle(3);
    check_idle_outputs("in_reset");
    rst_in = 1'b0;
    idle(2);
    check_idle_outputs("after_reset");

    // clean frame with exact latency
    stim = '{8'hAA, 8'h10, 8'h02, 8'h01, 8'h02, 8'hEB};
    run_stream("clean", 0, 0);
    check("clean_first_wr_lat", rel(first_wr_cyc, 5), 1);
    check("clean_ok_lat", rel(ok_cyc, 5), 3);
    check("clean_busy_fall_lat", rel(busy_fall_cyc, 5), 4);

    // leading noise and address wrap
    stim = '{8'h00, 8'h13, 8'hAA, 8'hFF, 8'h02, 8'h55, 8'h66, 8'h44};
    run_stream("wrap", 0, 0);

    // bad checksum immediately followed by a good frame
    stim = '{8'hAA, 8'h10, 8'h02, 8'h01, 8'h02, 8'hEC,
             8'hAA, 8'h10, 8'h02, 8'h01, 8'h02, 8'hEB};
    run_stream("csum", 0, 0);
    check("csum_err_lat", rel(err_cyc, 5), 1);

    // length errors
    stim = '{8'hAA, 8'h10, 8'h00};
    run_stream("len0", 0, 0);
    check("len0_err_lat", rel(err_cyc, 2), 1);
    stim = '{8'hAA, 8'h10, 8'h11};
    run_stream("len17", 0, 0);
    check("len17_busy", u.busy_out, 1'b0);

    // timeout after silence mid-frame
    clear_obs();
    stim = '{8'hAA, 8'h10, 8'h02, 8'h01};
    send_stim(0, 0);
    for (int k = 0; k < 300 && n_err == 0; k++) @(negedge clk_in);
    check("tmo_err_seen", n_err, 1);
    check("tmo_err_lat", rel(err_cyc, 3), TMO + 1);
    check("tmo_code", u.err_code_out, 2'd3);
    check("tmo_nwr", obs_wr.size(), 0);
    exp_code = 2'd3;
    wait_idle("tmo");

    // 99 idle cycles between bytes stays inside the frame
    stim = '{8'hAA, 8'h10, 8'h01, 8'h05, 8'hEA};
    run_stream("gap99", TMO - 1, TMO - 1);

    // full-length back-to-back frame, reset during the 8th write
    clear_obs();
    stim.delete();
    build_frame(8'h20, MAX_LEN, 1'b0);
    send_stim(0, 0);
    idle(7);
    check("rst_pre_wr_en", u.wr_en_out, 1'b1);
    check("rst_pre_wr_addr", u.wr_addr_out, 8'h27);
    check("rst_pre_wr_data", u.wr_data_out, stim[3+7]);
    #2;
    rst_in = 1'b1;
    #1;
    check("rst_wr_en", u.wr_en_out, 1'b0);
    check("rst_busy", u.busy_out, 1'b0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    exp_code = 2'd0;
    idle(30);
    check("rst_nwr", obs_wr.size(), 7);
    check("rst_nok", n_ok, 0);
    check("rst_nerr", n_err, 0);
    check("rst_code", u.err_code_out, 2'd0);

    stim.delete();
    build_frame(8'h40, MAX_LEN, 1'b0);
    run_stream("post_rst", 0, 0);

    // random frames with noise, bad lengths and corrupted checksums
    for (int it = 0; it < 40; it++) begin
      int kind = int'($urandom_range(9, 0));
      int nn = int'($urandom_range(3, 0));
      logic [7:0] a = 8'($urandom);
      stim.delete();
      for (int k = 0; k < nn; k++) begin
        logic [7:0] b = 8'($urandom);
        stim.push_back((b == 8'hAA) ? 8'h55 : b);
      end
      if (kind == 0) begin
        int l = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(255, MAX_LEN + 1));
        stim.push_back(8'hAA);
        stim.push_back(a);
        stim.push_back(8'(l));
      end else begin
        build_frame(a, int'($urandom_range(MAX_LEN, 1)), kind <= 2);
      end
      run_stream("rand", 0, 3);
    end

    check("ok_err_overlap", n_both, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
